// File: rtl/rectangle_pkg.sv
// Shared types and defaults for the RECTANGLE subkey bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rectangle_pkg;

  // Loader FSM: IDLE (nothing pending), LOAD (filling shadow), FULL (shadow
  // complete, waiting for the core to allow the swap).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } load_state_e;

  localparam int RECT_KEY_W       = 64;
  localparam int RECT128_NUM_KEYS = 26;

endpackage

// File: rtl/rectangle_skeybank_if.sv
// Handshake/bus bundle between the key-schedule producer/consumer and the bank.
// Latency: n/a (wires only).
// Backpressure: wr_ready throttles KeyIn; the read side has no backpressure.
// master drives load/write/swap/read requests; slave is the bank itself.
interface rectangle_skeybank_if
  import rectangle_pkg::*;
#(
  parameter int KEY_W    = RECT_KEY_W,
  parameter int NUM_KEYS = RECT128_NUM_KEYS
);
  localparam int ADDR_W = $clog2(NUM_KEYS);

  logic              load_start;
  logic              wr_valid;
  logic              wr_ready;
  logic [KEY_W-1:0]  KeyIn;
  logic              swap_en;
  logic              rd_en;
  logic [ADDR_W-1:0] RAddr;
  logic [KEY_W-1:0]  KeyOut;
  logic              rd_valid;
  logic              skey_ready;
  logic              load_busy;
  logic              load_done;

  modport master (
    output load_start, wr_valid, KeyIn, swap_en, rd_en, RAddr,
    input  wr_ready, KeyOut, rd_valid, skey_ready, load_busy, load_done
  );

  modport slave (
    input  load_start, wr_valid, KeyIn, swap_en, rd_en, RAddr,
    output wr_ready, KeyOut, rd_valid, skey_ready, load_busy, load_done
  );

endinterface

// File: rtl/rectangle_skey_ram.sv
// One bank of NUM_KEYS x KEY_W subkeys: synchronous write, combinational read.
// Latency: write visible on the cycle after we; read is same-cycle.
// Backpressure: none; out-of-range read addresses return 0.
// Ports: Clk, we/waddr/wdat (write), raddr/rdat (read).
module rectangle_skey_ram
  import rectangle_pkg::*;
#(
  parameter int KEY_W    = RECT_KEY_W,
  parameter int NUM_KEYS = RECT128_NUM_KEYS,
  parameter int ADDR_W   = $clog2(NUM_KEYS)
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [KEY_W-1:0]  wdat,
  input  logic [ADDR_W-1:0] raddr,
  output logic [KEY_W-1:0]  rdat
);
  // Contents are deliberately not reset; the bank gates reads with skey_ready.
  logic [KEY_W-1:0] mem [NUM_KEYS];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = (int'(raddr) < NUM_KEYS) ? mem[raddr] : '0;

endmodule

// File: rtl/rectangle_skeybank.sv
// Double-buffered subkey bank: loader fills the shadow bank, swap publishes it.
// Latency: read data registered, valid one cycle after rd_en.
// Backpressure: wr_ready only in LOAD; a full shadow waits for swap_en.
// Ports: Clk, flush (sync reset), bus (slave side of rectangle_skeybank_if).
module rectangle_skeybank
  import rectangle_pkg::*;
#(
  parameter int KEY_W    = RECT_KEY_W,
  parameter int NUM_KEYS = RECT128_NUM_KEYS
) (
  input  logic                 Clk,
  input  logic                 flush,
  rectangle_skeybank_if.slave  bus
);
  localparam int ADDR_W = $clog2(NUM_KEYS);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_KEYS - 1);

  load_state_e       state;
  logic [ADDR_W-1:0] wptr;
  logic              active_bank;
  logic              skey_ready_q;
  logic              rd_valid_q;
  logic              load_done_q;
  logic [KEY_W-1:0]  key_out_q;

  logic [KEY_W-1:0]  rdat0, rdat1, act_rdat;
  logic              wr_fire, swap, addr_ok;

  // A load_start in LOAD restarts the schedule, so the coincident write is dropped.
  assign wr_fire  = (state == LOAD) && bus.wr_valid && !bus.load_start;
  // With no valid schedule published yet, nothing can be disturbed: swap at once.
  assign swap     = (state == FULL) && (bus.swap_en || !skey_ready_q);
  assign act_rdat = active_bank ? rdat1 : rdat0;
  assign addr_ok  = int'(bus.RAddr) < NUM_KEYS;

  // Shadow is always !active_bank, so the active bank is never written.
  rectangle_skey_ram #(.KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS), .ADDR_W(ADDR_W)) u_bank0 (
    .Clk   (Clk),
    .we    (wr_fire && active_bank),
    .waddr (wptr),
    .wdat  (bus.KeyIn),
    .raddr (bus.RAddr),
    .rdat  (rdat0)
  );

  rectangle_skey_ram #(.KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS), .ADDR_W(ADDR_W)) u_bank1 (
    .Clk   (Clk),
    .we    (wr_fire && !active_bank),
    .waddr (wptr),
    .wdat  (bus.KeyIn),
    .raddr (bus.RAddr),
    .rdat  (rdat1)
  );

  always_ff @(posedge Clk) begin
    if (flush) begin
      state        <= IDLE;
      wptr         <= '0;
      active_bank  <= 1'b0;
      skey_ready_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      load_done_q  <= 1'b0;
      key_out_q    <= '0;
    end else begin
      load_done_q <= 1'b0;
      rd_valid_q  <= bus.rd_en;
      // Uses pre-edge active_bank, so a read on the swap edge sees the old bank.
      if (bus.rd_en) key_out_q <= (addr_ok && skey_ready_q) ? act_rdat : '0;

      case (state)
        IDLE: begin
          if (bus.load_start) begin
            state <= LOAD;
            wptr  <= '0;
          end
        end
        LOAD: begin
          if (bus.load_start) begin
            wptr <= '0;
          end else if (wr_fire) begin
            if (wptr == LAST_PTR) begin
              state <= FULL;
              wptr  <= '0;
            end else begin
              wptr <= wptr + ADDR_W'(1);
            end
          end
        end
        FULL: begin
          if (swap) begin
            active_bank  <= ~active_bank;
            skey_ready_q <= 1'b1;
            load_done_q  <= 1'b1;
            // A coincident load_start begins filling the new shadow bank.
            state        <= bus.load_start ? LOAD : IDLE;
            wptr         <= '0;
          end else if (bus.load_start) begin
            state <= LOAD;
            wptr  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          wptr  <= '0;
        end
      endcase
    end
  end

  assign bus.wr_ready   = (state == LOAD);
  assign bus.load_busy  = (state != IDLE);
  assign bus.skey_ready = skey_ready_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.load_done  = load_done_q;
  assign bus.KeyOut     = key_out_q;

endmodule

// File: tb/tb_rectangle_skeybank.sv
module tb_rectangle_skeybank;
  localparam int KW = 64;
  localparam int NK = 26;

  logic Clk = 1'b0;
  logic flush;
  always #5 Clk = ~Clk;

  rectangle_skeybank_if #(.KEY_W(KW), .NUM_KEYS(NK)) bus ();

  rectangle_skeybank #(.KEY_W(KW), .NUM_KEYS(NK)) dut (
    .Clk   (Clk),
    .flush (flush),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the published schedule plus the list of keys collected
  // by the loader since the last (re)start.
  logic [KW-1:0] sched [NK];
  logic [KW-1:0] pend [$];
  bit            loading  = 0;
  bit            ready    = 0;
  bit            exp_done = 0;
  bit            exp_rv   = 0;
  logic [KW-1:0] rdq [$];
  logic [KW-1:0] last_ko  = '0;
  bit            mon_en   = 0;
  int            done_cnt = 0;

  task automatic chk(input string nm, input logic [KW-1:0] got, input logic [KW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit full, swp;
    if (flush) begin
      loading = 0; ready = 0; exp_done = 0; exp_rv = 0;
      pend.delete(); rdq.delete(); last_ko = '0;
      return;
    end
    exp_rv = bus.rd_en;
    if (bus.rd_en)
      rdq.push_back((ready && int'(bus.RAddr) < NK) ? sched[bus.RAddr] : '0);
    full = loading && (pend.size() == NK);
    swp  = full && (bus.swap_en || !ready);
    exp_done = swp;
    if (swp) begin
      for (int i = 0; i < NK; i++) sched[i] = pend[i];
      ready = 1; loading = 0; pend.delete();
    end
    if (bus.load_start) begin
      loading = 1; pend.delete();
    end else if (loading && !full && bus.wr_valid) begin
      pend.push_back(bus.KeyIn);
    end
  endtask

  task automatic drive(input bit f, input bit ls, input bit wv, input logic [KW-1:0] k,
                       input bit se, input bit re, input logic [4:0] ra);
    flush = f; bus.load_start = ls; bus.wr_valid = wv; bus.KeyIn = k;
    bus.swap_en = se; bus.rd_en = re; bus.RAddr = ra;
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input bit se);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, se, 0, 0);
  endtask

  task automatic rd(input logic [4:0] a, input bit se);
    drive(0, 0, 0, '0, se, 1, a);
  endtask

  // Feed n keys with random wr_valid gaps; mode 0 = i*0x0101.., 1 = inverted, 2 = random.
  task automatic load_keys(input int n, input int mode, input bit se);
    int w = 0;
    logic [KW-1:0] v;
    while (w < n) begin
      bit wv = ($urandom_range(0, 3) != 0);
      case (mode)
        0:       v = 64'(w) * 64'h0101010101010101;
        1:       v = ~(64'(w) * 64'h0101010101010101);
        default: v = {$urandom, $urandom};
      endcase
      drive(0, 0, wv, v, se, 0, 0);
      if (wv) w++;
    end
  endtask

  // Monitor: compares every cycle away from the active edge.
  initial begin
    logic [KW-1:0] e;
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        chk("wr_ready",   64'(bus.wr_ready),   64'(loading && pend.size() < NK));
        chk("load_busy",  64'(bus.load_busy),  64'(loading));
        chk("skey_ready", 64'(bus.skey_ready), 64'(ready));
        chk("load_done",  64'(bus.load_done),  64'(exp_done));
        chk("rd_valid",   64'(bus.rd_valid),   64'(exp_rv));
        if (bus.load_done === 1'b1) done_cnt++;
        if (bus.rd_valid === 1'b1) begin
          if (rdq.size() == 0) begin
            chk("rd_unexpected", 64'(bus.rd_valid), 64'd0);
          end else begin
            e = rdq.pop_front();
            chk("KeyOut", bus.KeyOut, e);
            last_ko = e;
          end
        end else begin
          chk("KeyOut_hold", bus.KeyOut, last_ko);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    drive(1, 0, 0, '0, 0, 0, 0);
    mon_en = 1;
    drive(1, 0, 0, '0, 0, 0, 0);

    // Read before any schedule: zero data, valid strobe.
    rd(5'd0, 0);
    idle(2, 0);

    // First load auto-swaps because no schedule is published yet.
    d0 = done_cnt;
    drive(0, 1, 0, '0, 0, 0, 0);
    load_keys(NK, 0, 0);
    idle(3, 0);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    rd(5'd25, 0);
    rd(5'd0, 0);
    idle(2, 0);

    // Second load holds in FULL until swap_en; reads still see old values.
    drive(0, 1, 0, '0, 0, 0, 0);
    load_keys(NK, 1, 0);
    idle(4, 0);
    rd(5'd3, 0);
    rd(5'd10, 0);
    drive(0, 0, 0, '0, 1, 1, 5'd3);   // read on the swap edge: old bank
    rd(5'd3, 0);
    idle(2, 0);

    // Out-of-range addresses.
    for (int a = 26; a < 32; a++) rd(5'(a), 0);
    idle(2, 0);

    // Restart after 10 writes, then a full schedule.
    drive(0, 1, 0, '0, 1, 0, 0);
    load_keys(10, 2, 1);
    drive(0, 1, 0, '0, 1, 0, 0);
    load_keys(NK, 2, 1);
    idle(2, 0);
    for (int a = 0; a < NK; a++) rd(5'(a), 0);
    idle(2, 0);

    // load_start coincident with a swap.
    drive(0, 1, 0, '0, 0, 0, 0);
    load_keys(NK, 2, 0);
    idle(2, 0);
    drive(0, 1, 0, '0, 1, 1, 5'd7);
    load_keys(NK, 2, 0);
    idle(2, 1);
    for (int a = 0; a < NK; a += 5) rd(5'(a), 0);

    // Flush mid-load at wptr 13, then reload from zero.
    drive(0, 1, 0, '0, 0, 0, 0);
    load_keys(13, 2, 0);
    drive(1, 0, 1, 64'hdead_beef_0000_0001, 1, 1, 5'd1);
    idle(2, 0);
    rd(5'd1, 0);
    drive(0, 1, 0, '0, 0, 0, 0);
    load_keys(NK, 2, 0);
    idle(2, 0);
    for (int a = 0; a < NK; a++) rd(5'(a), 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 7),
            {$urandom, $urandom},
            ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 31)));
    end
    idle(3, 0);
    chk("rdq_drained", 64'(rdq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rectangle_skeybank.md
RECTANGLE_SKEYBANK -- requirements
Module: rectangle_skeybank

Interface
REQ-001 The block SHALL have parameter KEY_W, default 64, subkey width in bits.
REQ-002 The block SHALL have parameter NUM_KEYS, default 26, subkeys per schedule (2..32).
REQ-003 The block SHALL have localparam ADDR_W = $clog2(NUM_KEYS), the address width.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port load_start, input, 1 bit: begin loading a new schedule into the shadow bank.
REQ-007 The block SHALL have port wr_valid, input, 1 bit: KeyIn valid.
REQ-008 The block SHALL have port wr_ready, output, 1 bit: the block accepts KeyIn.
REQ-009 The block SHALL have port KeyIn, input, KEY_W bits: subkey to write.
REQ-010 The block SHALL have port swap_en, input, 1 bit: the core permits shadow/active bank swap.
REQ-011 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-012 The block SHALL have port RAddr, input, ADDR_W bits: read address.
REQ-013 The block SHALL have port KeyOut, output, KEY_W bits: registered read data.
REQ-014 The block SHALL have port rd_valid, output, 1 bit: KeyOut valid, one cycle after rd_en.
REQ-015 The block SHALL have port skey_ready, output, 1 bit: the active bank holds a complete schedule.
REQ-016 The block SHALL have port load_busy, output, 1 bit: the loader is in LOAD or FULL.
REQ-017 The block SHALL have port load_done, output, 1 bit: one-cycle pulse on the swap edge.

Function
REQ-018 The block SHALL implement two banks of NUM_KEYS x KEY_W, tracked by active_bank (read side) and shadow bank = !active_bank (write side).
REQ-019 The loader FSM SHALL have states IDLE, LOAD and FULL; wr_ready = (state==LOAD).
REQ-020 The FSM SHALL go IDLE->LOAD on load_start and clear wptr to 0.
REQ-021 In LOAD, each wr_valid&&wr_ready cycle SHALL write KeyIn to shadow[wptr] and increment wptr; the write at wptr==NUM_KEYS-1 SHALL move the FSM to FULL.
REQ-022 The FSM SHALL go FULL->IDLE on the edge where (swap_en || !skey_ready); on that edge active_bank toggles, skey_ready becomes 1 and load_done pulses.
REQ-023 load_start in LOAD or FULL SHALL restart: state becomes LOAD, wptr=0, and partial shadow contents are discarded; the active bank is untouched.
REQ-024 wr_valid outside LOAD SHALL be ignored, with no write and no pointer change.
REQ-025 A read SHALL have latency 1: rd_valid=1 on the cycle after rd_en; KeyOut = active[RAddr] sampled at the rd_en edge.
REQ-026 KeyOut SHALL be 0 when RAddr >= NUM_KEYS or skey_ready==0 at the sample edge.
REQ-027 A read on the swap edge SHALL return the pre-swap active bank.
REQ-028 KeyOut SHALL hold its value while rd_en==0, and rd_valid SHALL be 0 in those cycles.
REQ-029 load_start and a swap on the same edge SHALL complete the swap; the FSM then goes to LOAD for the new shadow bank.
REQ-030 Writes SHALL never target the active bank.

Reset
REQ-031 With flush=1 at a rising edge, the block SHALL set: state=IDLE, wptr=0, active_bank=0, skey_ready=0, rd_valid=0, KeyOut=0, load_done=0, wr_ready=0.
REQ-032 The block SHALL NOT reset bank contents; reads return 0 until the first swap (REQ-026).
REQ-033 flush SHALL override all other inputs on the same edge, including mid-load and on the swap edge.

Structure
REQ-034 A shared package rectangle_pkg SHALL hold the loader state enum (IDLE/LOAD/FULL) and the defaults RECT_KEY_W=64 and RECT128_NUM_KEYS=26.
REQ-035 The design SHALL contain one sub-module, rectangle_skey_ram: a single-bank NUM_KEYS x KEY_W array with sync write and combinational read, instantiated twice.

Verification
REQ-036 The bench SHALL cover: flush, then rd_en at RAddr=0 -> next cycle rd_valid=1, KeyOut=0, skey_ready=0.
REQ-037 The bench SHALL cover: load_start, then 26 writes of KeyIn=i*0x0101010101010101 with swap_en=0 -> auto-swap (skey_ready was 0), load_done pulses once, reading RAddr=25 returns 0x1919191919191919.
REQ-038 The bench SHALL cover: second load of ~value with swap_en=0 -> FSM holds FULL, reads return the old values; swap_en=1 -> one cycle later RAddr=3 returns ~0x0303030303030303.
REQ-039 The bench SHALL cover: RAddr=26..31 with skey_ready=1 -> KeyOut=0, rd_valid=1.
REQ-040 The bench SHALL cover: load_start after 10 writes, then 26 writes -> the schedule contains only the later 26 values.
REQ-041 The bench SHALL cover: flush asserted mid-load at wptr=13 -> skey_ready=0, wr_ready=0, and the next load starts at wptr 0.
